piso_stream_serializer: RTL and testbench
=========================================

// Module: piso_stream_serializer
// PURPOSE
//  Parametrised parallel-in/serial-out shifter; successor to the fixed 4-bit loader.
//  Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clk, qualified by dout_valid.
//  Supports back-to-back frames with no gap, selectable bit order, frame-last marker and synchronous flush.
//  Sits between parallel datapath producers and single-wire serial links (SPI-like TX, LED chains).
// PARAMETERS
//  WIDTH       8  bits per word (>=2)
//  MSB_FIRST   1  1: din[WIDTH-1] sent first; 0: din[0] sent first
//  IDLE_LEVEL  0  value driven on dout when dout_valid=0
//  PARITY_ODD  0  parity sense when PISO_PARITY_EN defined (0 even, 1 odd); ignored otherwise
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      asynchronous, active-high reset
//  flush       in   1      sync abort of frame in progress
//  din         in   WIDTH  parallel word
//  din_valid   in   1      din holds a word to send
//  din_ready   out  1      block accepts din this cycle
//  dout        out  1      serial bit (registered)
//  dout_valid  out  1      dout carries a frame bit (registered)
//  dout_last   out  1      dout is final bit of frame (registered)
//  busy        out  1      frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-frame): state=IDLE, shreg=0, cnt=0, dout=IDLE_LEVEL,
//    dout_valid=0, dout_last=0, busy=0; din_ready=0 while reset high; partial frame discarded.
//  - States: IDLE, SHIFT (+ PARITY with macro). FRAME_LEN = WIDTH (+1 with macro).
//  - din_ready = !reset & !flush & (state==IDLE | final bit on dout). Combinational, no din_valid dependency.
//  - Accept = din_valid & din_ready at a rising edge. On that edge: first bit -> dout,
//    dout_valid=1, remainder -> shreg, cnt=1, state=SHIFT. First bit visible 1 cycle after accept.
//  - SHIFT: each edge outputs next bit in MSB_FIRST order, cnt++. cnt width $clog2(WIDTH+1).
//  - dout_valid high exactly FRAME_LEN consecutive cycles per word; dout_last high only on final bit.
//  - Final bit with accept: next word's first bit follows on next edge, no idle gap (full throughput).
//  - Final bit without accept: next edge -> IDLE, dout=IDLE_LEVEL, dout_valid=0.
//  - din sampled only at accept; later din changes do not affect frame in progress.
//  - flush=1 at edge: -> IDLE, outputs as after reset (except async); flush beats din_valid (no accept).
//  - flush in IDLE: no effect besides din_ready=0 that cycle.
// CONFIGURATION
//  PISO_PARITY_EN defined: after WIDTH data bits, one PARITY bit = ^word ^ PARITY_ODD;
//    dout_last moves to parity bit; din_ready during parity bit (not last data bit).
//  PISO_PARITY_EN undefined: no PARITY state; frame is WIDTH bits; PARITY_ODD unused.
// TESTING
//  1 reset: assert mid-frame -> outputs at reset values same cycle; after release din_ready=1.
//  2 WIDTH=8 MSB_FIRST=1, din=8'hA5 one accept -> dout 1,0,1,0,0,1,0,1; dout_last on 8th; then IDLE.
//  3 MSB_FIRST=0, din=8'hA5 -> dout 1,0,1,0,0,1,0,1 reversed order = 1,0,1,0,0,1,0,1 LSB-first check with 8'h01 -> 1 then seven 0s.
//  4 back-to-back 8'hFF,8'h00 din_valid held -> 16 contiguous dout_valid cycles, dout 8x1 then 8x0, two dout_last pulses.
//  5 flush on 4th bit with din_valid=1 -> next edge dout_valid=0, busy=0, word not accepted; next word sent whole.
//  6 PISO_PARITY_EN, PARITY_ODD=0, din=8'h07 -> 9 bits, 9th=1, dout_last on 9th; with 8'h03 -> 9th=0.

Source files
------------

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out stream serializer with valid/ready input and full-throughput framing.
// Optional trailing parity bit when PISO_PARITY_EN is defined.
module piso_stream_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned IDLE_LEVEL = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy
);

  localparam int unsigned CntW     = $clog2(WIDTH + 1);
  localparam logic        IdleBit  = (IDLE_LEVEL != 0);
  localparam logic        MsbFirst = (MSB_FIRST != 0);

  if (WIDTH < 2 || MSB_FIRST > 1 || IDLE_LEVEL > 1 || PARITY_ODD > 1) begin : gen_param_check
    $error("piso_stream_serializer: illegal parameter value");
  end

`ifdef PISO_PARITY_EN
  localparam logic ParSense = (PARITY_ODD != 0);
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
  logic par_q, par_d;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             accept;

  // A new word may enter while the final bit of the current frame is on the wire.
  assign din_ready = !reset && !flush && (state_q == StIdle || last_q);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    last_d  = last_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (flush) begin
      state_d = StIdle;
      shreg_d = '0;
      cnt_d   = '0;
      dout_d  = IdleBit;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (accept) begin
      state_d = StShift;
      cnt_d   = CntW'(1);
      valid_d = 1'b1;
      last_d  = 1'b0;
`ifdef PISO_PARITY_EN
      par_d   = ^din;
`endif
      if (MsbFirst) begin
        dout_d  = din[WIDTH-1];
        shreg_d = din << 1;
      end else begin
        dout_d  = din[0];
        shreg_d = din >> 1;
      end
    end else begin
      case (state_q)
        StShift: begin
          if (cnt_q != CntW'(WIDTH)) begin
            cnt_d = cnt_q + CntW'(1);
            if (MsbFirst) begin
              dout_d  = shreg_q[WIDTH-1];
              shreg_d = shreg_q << 1;
            end else begin
              dout_d  = shreg_q[0];
              shreg_d = shreg_q >> 1;
            end
`ifdef PISO_PARITY_EN
            last_d = 1'b0;
`else
            last_d = (cnt_q == CntW'(WIDTH - 1));
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_d = StParity;
            dout_d  = par_q ^ ParSense;
            last_d  = 1'b1;
`else
            state_d = StIdle;
            shreg_d = '0;
            cnt_d   = '0;
            dout_d  = IdleBit;
            valid_d = 1'b0;
            last_d  = 1'b0;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        StParity: begin
          state_d = StIdle;
          shreg_d = '0;
          cnt_d   = '0;
          dout_d  = IdleBit;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= IdleBit;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus; accepted words are queued
// and every output cycle is compared against the bit expected from the dequeued word.
module tb_piso_stream_serializer;

  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  localparam logic ParOdd = 1'b0;

  logic         clk, reset, flush, din_valid;
  logic [W-1:0] din;
  logic         ready0, dout0, dv0, last0, busy0;
  logic         ready1, dout1, dv1, last1, busy1;

  piso_stream_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(0), .PARITY_ODD(0)) u_msb (
    .clk(clk), .reset(reset), .flush(flush), .din(din), .din_valid(din_valid),
    .din_ready(ready0), .dout(dout0), .dout_valid(dv0), .dout_last(last0), .busy(busy0)
  );

  piso_stream_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(0), .PARITY_ODD(0)) u_lsb (
    .clk(clk), .reset(reset), .flush(flush), .din(din), .din_valid(din_valid),
    .din_ready(ready1), .dout(dout1), .dout_valid(dv1), .dout_last(last1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard state: words waiting to be sent, word on the wire and its bit position.
  logic [W-1:0] wq[$];
  logic [W-1:0] cur;
  int           pos;
  bit           act;
  bit           accepted;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bitof(input logic [W-1:0] w, input int p, input bit m);
    if (p >= int'(W)) return (^w) ^ ParOdd;
    return m ? w[W-1-p] : w[p];
  endfunction

  task automatic check_outputs();
    logic exp_last;
    exp_last = act && (pos == FL - 1);
    check_eq("dv_msb",   32'(dv0),   32'(act));
    check_eq("dv_lsb",   32'(dv1),   32'(act));
    check_eq("last_msb", 32'(last0), 32'(exp_last));
    check_eq("last_lsb", 32'(last1), 32'(exp_last));
    check_eq("busy_msb", 32'(busy0), 32'(act));
    check_eq("busy_lsb", 32'(busy1), 32'(act));
    check_eq("dout_msb", 32'(dout0), 32'(act ? bitof(cur, pos, 1'b1) : 1'b0));
    check_eq("dout_lsb", 32'(dout1), 32'(act ? bitof(cur, pos, 1'b0) : 1'b0));
  endtask

  // One clock: drive inputs, check readiness, update scoreboard at the edge, check outputs.
  task automatic step(input logic v, input logic [W-1:0] d, input logic f);
    logic exp_ready;
    din_valid = v;
    din       = d;
    flush     = f;
    #1;
    exp_ready = !reset && !f && (!act || pos == FL - 1);
    check_eq("ready_msb", 32'(ready0), 32'(exp_ready));
    check_eq("ready_lsb", 32'(ready1), 32'(exp_ready));
    @(posedge clk);
    accepted = v && exp_ready;
    if (reset || f) begin
      wq.delete();
      act = 1'b0;
    end else begin
      if (accepted) wq.push_back(d);
      if (act && pos < FL - 1) begin
        pos++;
      end else if (wq.size() > 0) begin
        cur = wq.pop_front();
        pos = 0;
        act = 1'b1;
      end else begin
        act = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_word(input logic [W-1:0] w, output logic [FL-1:0] s0,
                           output logic [FL-1:0] s1, output int nlast);
    int got   = 0;
    int guard = 0;
    bit done  = 0;
    s0 = '0;
    s1 = '0;
    nlast = 0;
    while (got < FL && guard < FL + 10) begin
      step(!done, w, 1'b0);
      guard++;
      if (accepted) done = 1;
      if (dv0) begin
        s0 = {s0[FL-2:0], dout0};
        s1 = {s1[FL-2:0], dout1};
        got++;
        if (last0) nlast++;
      end
    end
    check_eq("frame_len", 32'(got), 32'(FL));
  endtask

  initial begin
    logic [FL-1:0] s0, s1;
    int nl, run, lasts, ones, idx;
    logic [W-1:0] words [2];

    clk = 0; reset = 1; flush = 0; din_valid = 0; din = '0;
    act = 0; pos = 0; cur = '0; accepted = 0;
    #1;
    check_eq("rst_dv",    32'(dv0),    32'd0);
    check_eq("rst_dout",  32'(dout0),  32'd0);
    check_eq("rst_busy",  32'(busy0),  32'd0);
    check_eq("rst_ready", 32'(ready0), 32'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    step(1'b0, '0, 1'b0);

    // Single words in both bit orders.
    send_word(8'hA5, s0, s1, nl);
    check_eq("a5_msb",  32'(s0[FL-1 -: W]), 32'h0A5);
    check_eq("a5_lsb",  32'(s1[FL-1 -: W]), 32'h0A5);
    check_eq("a5_last", 32'(nl), 32'd1);
    step(1'b0, '0, 1'b0);
    send_word(8'h01, s0, s1, nl);
    check_eq("01_msb", 32'(s0[FL-1 -: W]), 32'h001);
    check_eq("01_lsb", 32'(s1[FL-1 -: W]), 32'h080);
    step(1'b0, '0, 1'b0);

    // Back-to-back with din_valid held.
    words[0] = 8'hFF;
    words[1] = 8'h00;
    idx = 0; run = 0; lasts = 0; ones = 0;
    for (int c = 0; c < 4 * FL; c++) begin
      step(idx < 2, words[(idx < 2) ? idx : 1], 1'b0);
      if (accepted) idx++;
      if (dv0) begin
        run++;
        if (last0) lasts++;
        if (dout0) ones++;
      end else if (run > 0) begin
        break;
      end
    end
    check_eq("b2b_run",   32'(run),   32'(2 * FL));
    check_eq("b2b_lasts", 32'(lasts), 32'd2);
    check_eq("b2b_ones",  32'(ones),  32'(W));

    // Flush on the fourth bit while a new word is offered.
    step(1'b1, 8'h3C, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b1, 8'hC3, 1'b1);
    check_eq("flush_dv",   32'(dv0),   32'd0);
    check_eq("flush_busy", 32'(busy0), 32'd0);
    step(1'b0, '0, 1'b0);
    send_word(8'h96, s0, s1, nl);
    check_eq("post_flush_msb", 32'(s0[FL-1 -: W]), 32'h096);
    check_eq("post_flush_lsb", 32'(s1[FL-1 -: W]), 32'h069);
    step(1'b0, '0, 1'b0);

    // Flush while idle only blocks that cycle.
    step(1'b1, 8'h11, 1'b1);
    step(1'b0, '0, 1'b0);

    // Asynchronous reset mid-frame.
    step(1'b1, 8'hE7, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    #2;
    reset = 1;
    wq.delete();
    act = 0;
    #1;
    check_eq("arst_dv",    32'(dv0),    32'd0);
    check_eq("arst_dout",  32'(dout0),  32'd0);
    check_eq("arst_last",  32'(last0),  32'd0);
    check_eq("arst_busy",  32'(busy0),  32'd0);
    check_eq("arst_ready", 32'(ready1), 32'd0);
    @(negedge clk);
    step(1'b0, '0, 1'b0);
    reset = 0;
    step(1'b0, '0, 1'b0);

    // Parity bit (or plain frame in the default build).
    send_word(8'h07, s0, s1, nl);
`ifdef PISO_PARITY_EN
    check_eq("par_07", 32'(s0[0]), 32'd1);
    check_eq("par_07_last", 32'(nl), 32'd1);
    step(1'b0, '0, 1'b0);
    send_word(8'h03, s0, s1, nl);
    check_eq("par_03", 32'(s0[0]), 32'd0);
`else
    check_eq("w07_msb", 32'(s0), 32'h007);
    check_eq("w07_lsb", 32'(s1), 32'h0E0);
`endif
    step(1'b0, '0, 1'b0);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 30) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
